// File: rtl/and_gate_sweep_ctrl_if.sv
// Bundle between the sweep controller, the start/LED panel and the gate block under test.
// The controller uses the slave modport; the panel/gate side uses master.
interface and_gate_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       e;
    logic       f;
    logic       g;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_vec;
    logic [2:0] fail_mask;

    modport slave (
        input  start, abort, e, f, g,
        output a, b, c, d, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask
    );

    modport master (
        output start, abort, e, f, g,
        input  a, b, c, d, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask
    );
endinterface

// File: rtl/and_gate_sweep_ctrl.sv
// Clocked self-checking sweep of a 4-input gate block over all 16 vectors,
// holding each vector DWELL cycles and comparing e,f,g against a built-in golden model.
//
// state  | meaning
// S_IDLE | waiting for start; stimulus held at 0
// S_RUN  | driving vec, counting dwell, comparing on the last dwell cycle
// S_DONE | sweep finished; results held until next start
module and_gate_sweep_ctrl #(
    parameter int unsigned DWELL = 10,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    and_gate_sweep_ctrl_if.slave sw
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       err_q, err_d;
    logic             fvalid_q, fvalid_d;
    logic [3:0]       fvec_q, fvec_d;
    logic [2:0]       fmask_q, fmask_d;

    logic [2:0]       golden;
    logic [2:0]       mismatch;

    assign golden   = {vec_q[3] & vec_q[2], vec_q[1] & vec_q[0], &vec_q};
    assign mismatch = {sw.e, sw.f, sw.g} ^ golden;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            fvec_q   <= '0;
            fmask_q  <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            fvec_q   <= fvec_d;
            fmask_q  <= fmask_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        fvec_d   = fvec_q;
        fmask_d  = fmask_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (sw.start) begin
                    state_d  = S_RUN;
                    vec_d    = '0;
                    cnt_d    = '0;
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    fvec_d   = '0;
                    fmask_d  = '0;
                end
            end
            S_RUN: begin
                // abort wins over the compare/advance on the same edge
                if (sw.abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    if (mismatch != 3'b000) begin
                        err_d = err_q + 5'd1;
                        if (!fvalid_q) begin
                            fvalid_d = 1'b1;
                            fvec_d   = vec_q;
                            fmask_d  = mismatch;
                        end
                    end
                    if (vec_q == 4'hF) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        {sw.a, sw.b, sw.c, sw.d} = (state_q == S_RUN) ? vec_q : 4'h0;
        sw.busy       = (state_q == S_RUN);
        sw.done       = (state_q == S_DONE);
        sw.pass       = (state_q == S_DONE) && (err_q == 5'd0);
        sw.err_count  = err_q;
        sw.fail_valid = fvalid_q;
        sw.fail_vec   = fvec_q;
        sw.fail_mask  = fmask_q;
    end

endmodule

// File: tb/tb_and_gate_sweep_ctrl.sv
// Scoreboard bench for and_gate_sweep_ctrl: a configurable faulty gate block,
// sweep-level expectations from a reference model, and a monitor checking each completion.
module tb_and_gate_sweep_ctrl;

    localparam int DW  = 2;
    localparam int CW  = 8;
    localparam int SWEEP = 16 * DW;

    typedef struct packed {
        logic [4:0] err;
        logic       fv;
        logic [3:0] fvec;
        logic [2:0] fmask;
    } exp_t;

    logic clk;
    logic rst_n;
    and_gate_sweep_ctrl_if sw();

    and_gate_sweep_ctrl #(.DWELL(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    logic [2:0] flip [16];
    logic       stuck_e1;
    logic       stuck_g0;
    logic [3:0] vec_w;

    // gate block under test, with optional stuck-at and per-vector flip faults
    assign vec_w = {sw.a, sw.b, sw.c, sw.d};
    assign sw.e  = stuck_e1 | ((sw.a & sw.b) ^ flip[vec_w][2]);
    assign sw.f  = (sw.c & sw.d) ^ flip[vec_w][1];
    assign sw.g  = ~stuck_g0 & ((&vec_w) ^ flip[vec_w][0]);

    function automatic logic [2:0] ref_golden(int v);
        logic [2:0] r;
        r[2] = (v >= 12);
        r[1] = ((v % 4) == 3);
        r[0] = (v == 15);
        return r;
    endfunction

    function automatic logic [2:0] ref_gate(int v);
        logic [2:0] o;
        o = ref_golden(v) ^ flip[v];
        if (stuck_e1) o[2] = 1'b1;
        if (stuck_g0) o[0] = 1'b0;
        return o;
    endfunction

    // results of comparing the first n vectors
    function automatic exp_t ref_model(int n);
        exp_t r;
        logic [2:0] m;
        r = '0;
        for (int v = 0; v < n; v++) begin
            m = ref_gate(v) ^ ref_golden(v);
            if (m != 3'b000) begin
                r.err = r.err + 5'd1;
                if (!r.fv) begin
                    r.fv    = 1'b1;
                    r.fvec  = 4'(v);
                    r.fmask = m;
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic clear_faults();
        stuck_e1 = 1'b0;
        stuck_g0 = 1'b0;
        for (int i = 0; i < 16; i++) flip[i] = 3'b000;
    endtask

    task automatic pulse_start(input logic with_abort);
        @(negedge clk);
        sw.start = 1'b1;
        sw.abort = with_abort;
        @(negedge clk);
        sw.start = 1'b0;
        sw.abort = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < SWEEP + 20; i++) begin
            @(negedge clk);
            if (sw.done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) timeout(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_vec(input int v, input string name);
        bit seen = 0;
        for (int i = 0; i < SWEEP + 20; i++) begin
            @(negedge clk);
            if (sw.busy && vec_w == 4'(v)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) timeout(name);
    endtask

    task automatic run_sweep(input string name, input logic with_abort);
        exp_q.push_back(ref_model(16));
        pulse_start(with_abort);
        wait_done(name);
    endtask

    // monitor: per-cycle stimulus order and end-of-sweep results
    int   bcnt;
    logic prev_busy;
    logic prev_done;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
            bcnt      = 0;
        end else begin
            if (sw.busy) begin
                if (!prev_busy) bcnt = 0;
                chk("vec", int'(vec_w), bcnt / DW);
                bcnt++;
            end
            if (sw.done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sweep_cycles", bcnt, SWEEP);
                    chk("err_count", int'(sw.err_count), int'(e.err));
                    chk("fail_valid", int'(sw.fail_valid), int'(e.fv));
                    chk("fail_vec", int'(sw.fail_vec), int'(e.fvec));
                    chk("fail_mask", int'(sw.fail_mask), int'(e.fmask));
                    chk("pass", int'(sw.pass), int'(e.err == 5'd0));
                    chk("done_vec_zero", int'(vec_w), 0);
                    chk("done_busy", int'(sw.busy), 0);
                end
            end
            prev_busy = sw.busy;
            prev_done = sw.done;
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_abcd"}, int'(vec_w), 0);
        chk({name, "_busy"}, int'(sw.busy), 0);
        chk({name, "_done"}, int'(sw.done), 0);
        chk({name, "_pass"}, int'(sw.pass), 0);
        chk({name, "_err"}, int'(sw.err_count), 0);
        chk({name, "_fv"}, int'(sw.fail_valid), 0);
        chk({name, "_fvec"}, int'(sw.fail_vec), 0);
        chk({name, "_fmask"}, int'(sw.fail_mask), 0);
    endtask

    initial begin
        exp_t pe;
        rst_n    = 1'b0;
        sw.start = 1'b0;
        sw.abort = 1'b0;
        clear_faults();
        #3;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(sw.busy), 0);

        // clean gate
        run_sweep("clean", 1'b0);

        // g stuck-at-0
        clear_faults();
        stuck_g0 = 1'b1;
        run_sweep("g_sa0", 1'b0);

        // e stuck-at-1, restarted from DONE with start and abort together
        clear_faults();
        stuck_e1 = 1'b1;
        run_sweep("e_sa1", 1'b1);

        // abort outside RUN does nothing
        @(negedge clk);
        sw.abort = 1'b1;
        @(negedge clk);
        sw.abort = 1'b0;
        chk("abort_done_hold", int'(sw.done), 1);
        chk("abort_done_err", int'(sw.err_count), 12);

        // abort during vec 5 keeps partial results of vectors 0..4
        pulse_start(1'b0);
        wait_vec(5, "abort_wait");
        sw.abort = 1'b1;
        @(negedge clk);
        sw.abort = 1'b0;
        pe = ref_model(5);
        chk("abort_busy", int'(sw.busy), 0);
        chk("abort_done", int'(sw.done), 0);
        chk("abort_pass", int'(sw.pass), 0);
        chk("abort_abcd", int'(vec_w), 0);
        chk("abort_err", int'(sw.err_count), int'(pe.err));
        chk("abort_fv", int'(sw.fail_valid), int'(pe.fv));
        chk("abort_fmask", int'(sw.fail_mask), int'(pe.fmask));
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", int'(sw.busy), 0);

        clear_faults();
        run_sweep("after_abort", 1'b0);

        // start pulsed mid-sweep is ignored
        exp_q.push_back(ref_model(16));
        pulse_start(1'b0);
        wait_vec(8, "midstart_wait");
        sw.start = 1'b1;
        @(negedge clk);
        sw.start = 1'b0;
        wait_done("midstart");
        run_sweep("rerun_from_done", 1'b0);

        // asynchronous reset at vec 10
        stuck_g0 = 1'b1;
        pulse_start(1'b0);
        wait_vec(10, "rst_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_busy", int'(sw.busy), 0);
        end
        chk("post_reset_done", int'(sw.done), 0);

        // random per-vector fault patterns
        for (int n = 0; n < 6; n++) begin
            clear_faults();
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(3) == 0) flip[i] = 3'($urandom_range(7, 1));
            end
            stuck_e1 = ($urandom_range(7) == 0);
            run_sweep("random", 1'($urandom_range(1)));
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/and_gate_sweep_ctrl.md
Name: and_gate_sweep_ctrl

Overview:
- Hardware sequencer that exercises a four-input gate block (inputs a,b,c,d; outputs e,f,g) with all 16 input combinations.
- Holds each vector a fixed number of cycles, samples the gate outputs, compares them against a built-in golden model, and reports pass/fail.
- Sits between a board-level start button/LED panel and the gate block; replaces the free-running toggle stimulus with a clocked, self-checking sweep.

Parameters:
- DWELL, 10, clock cycles each vector is held (legal range 1..255).
- CNT_W, 8, width of the dwell counter (must satisfy 2^CNT_W > DWELL).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- abort  input  1  synchronous cancel of a running sweep.
- a  output  1  gate input, MSB of vector.
- b  output  1  gate input.
- c  output  1  gate input.
- d  output  1  gate input, LSB of vector (toggles fastest).
- e  input  1  gate output under test.
- f  input  1  gate output under test.
- g  input  1  gate output under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep completed; sticky until next start.
- pass  output  1  done and zero mismatches.
- err_count  output  5  number of mismatching vectors (0..16).
- fail_valid  output  1  at least one mismatch recorded this sweep.
- fail_vec  output  4  {a,b,c,d} of the first mismatching vector.
- fail_mask  output  3  {e,f,g} mismatch bits of the first failing vector.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0; state is IDLE; vector is 0; dwell counter is 0.
- Golden model: exp_e = a&b; exp_f = c&d; exp_g = a&b&c&d.
- Stimulus outputs: {a,b,c,d} = vec[3:0], registered.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Next state is RUN.
  - Clear vec, dwell counter, err_count, fail_valid, fail_vec, fail_mask and done.
  - busy=1 from the following cycle.
- RUN:
  - Dwell counter increments each cycle.
  - On the cycle where the counter equals DWELL-1, compare e,f,g with the golden values for the current vec.
  - Any difference increments err_count by exactly 1 per vector, regardless of how many bits differ.
  - If fail_valid=0, the same edge captures fail_vec=vec and fail_mask = XOR bits, and sets fail_valid=1.
  - On the same edge: if vec≠15, increment vec and clear the counter; if vec=15, go to DONE.
- Timing: each vector is driven for exactly DWELL cycles. done rises exactly 16*DWELL cycles after the start-accept edge.
- DONE: busy=0, done=1, pass=(err_count==0); {a,b,c,d} return to 0; result registers hold.
- Simultaneous events:
  - start while in RUN is ignored.
  - abort in RUN has priority over the compare/advance on that edge: go to IDLE, a..d=0, busy=0, done=0, pass=0. err_count and fail_* keep their partial values until the next start.
  - abort outside RUN has no effect.
  - start and abort together in IDLE or DONE: start wins.
- Reset mid-sweep: immediate return to reset values with no completion report.
- err_count saturates naturally at 16; no wrap-around.

Test Plan:
- Correct gate model, DWELL=2, start pulse → a..d step 0000..1111 with d toggling every 2 cycles; done=1 at 32 cycles; err_count=0; pass=1; fail_valid=0.
- g stuck-at-0 → err_count=1, fail_vec=4'hF, fail_mask=3'b001, pass=0.
- e stuck-at-1 → err_count=12, fail_vec=4'h0, fail_mask=3'b100 (e=1 and g stays 0 at vec 0).
- abort during vec=5 → next cycle IDLE, a..d=0, busy=0, done=0. A later start runs a full clean sweep with err_count reset to 0.
- start pulsed again mid-sweep at vec=8 → ignored; sweep finishes at 32 cycles. Second start from DONE clears done and re-runs.
- rst_n low at vec=10 (asynchronous, off clock edge) → all outputs 0 immediately; after release, no activity until start.
